// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
interface ex_div_if #(
    parameter int unsigned DIV_W = 32
);
    logic                 signed_div_i;
    logic [DIV_W-1:0]     opdata1_i;
    logic [DIV_W-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*DIV_W-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider for div/divu, one quotient bit per cycle.
// Define DIV_SIGNED_EN to build signed operand negation and result fix-up.
module ex_div #(
    parameter int unsigned DIV_W = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    ex_div_if.slave   bus
);
    typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [2*DIV_W:0]     work, work_n;
    logic [DIV_W-1:0]     divisor, divisor_n;
    logic [2*DIV_W-1:0]   result, result_n;
    logic                 ready, ready_n;
    logic [DIV_W:0]       trial;
    logic [DIV_W-1:0]     quot, rem;
    logic [DIV_W-1:0]     op1_abs, op2_abs;
    logic                 neg1, neg2, neg1_n, neg2_n;

    assign bus.result_o = result;
    assign bus.ready_o  = ready;

    always_comb begin
        trial = work[2*DIV_W:DIV_W] - {1'b0, divisor};
`ifdef DIV_SIGNED_EN
        neg1_n  = bus.signed_div_i & bus.opdata1_i[DIV_W-1];
        neg2_n  = bus.signed_div_i & bus.opdata2_i[DIV_W-1];
        op1_abs = neg1_n ? -bus.opdata1_i : bus.opdata1_i;
        op2_abs = neg2_n ? -bus.opdata2_i : bus.opdata2_i;
        quot    = (neg1 ^ neg2) ? -work[DIV_W-1:0] : work[DIV_W-1:0];
        rem     = neg1 ? -work[2*DIV_W:DIV_W+1] : work[2*DIV_W:DIV_W+1];
`else
        neg1_n  = 1'b0;
        neg2_n  = 1'b0;
        op1_abs = bus.opdata1_i;
        op2_abs = bus.opdata2_i;
        quot    = work[DIV_W-1:0];
        rem     = work[2*DIV_W:DIV_W+1];
`endif
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        divisor_n = divisor;
        result_n  = result;
        ready_n   = ready;
        case (state)
            DivFree: begin
                ready_n  = 1'b0;
                result_n = '0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_n = DivByZero;
                    end else begin
                        state_n   = DivOn;
                        cnt_n     = '0;
                        divisor_n = op2_abs;
                        work_n    = {{DIV_W{1'b0}}, op1_abs, 1'b0};
                    end
                end
            end
            DivByZero: begin
                work_n  = '0;
                state_n = DivEnd;
            end
            DivOn: begin
                if (bus.annul_i) begin
                    state_n  = DivFree;
                    ready_n  = 1'b0;
                    result_n = '0;
                end else if (cnt == CNT_W'(DIV_W)) begin
                    state_n  = DivEnd;
                    cnt_n    = '0;
                    ready_n  = 1'b1;
                    result_n = {rem, quot};
                end else begin
                    // Trial bit DIV_W set means the subtraction underflowed: keep the partial remainder.
                    if (trial[DIV_W])
                        work_n = {work[2*DIV_W-1:0], 1'b0};
                    else
                        work_n = {trial[DIV_W-1:0], work[DIV_W-1:0], 1'b1};
                    cnt_n = cnt + 1'b1;
                end
            end
            DivEnd: begin
                if (bus.start_i) begin
                    ready_n  = 1'b1;
                    result_n = {rem, quot};
                end else begin
                    state_n  = DivFree;
                    ready_n  = 1'b0;
                    result_n = '0;
                end
            end
            default: state_n = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DivFree;
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
            neg1    <= 1'b0;
            neg2    <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            work    <= work_n;
            divisor <= divisor_n;
            result  <= result_n;
            ready   <= ready_n;
            // Operand signs are only captured when a new division is accepted.
            if (state == DivFree && state_n == DivOn) begin
                neg1 <= neg1_n;
                neg2 <= neg2_n;
            end
        end
    end
endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: driver queues expected results, monitor checks each result_o.
module tb_ex_div;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = '0;
    logic        ready_q = 1'b0;

    always #5 clk = ~clk;

    ex_div_if #(.DIV_W(32)) bus ();

    ex_div #(.DIV_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sd);
        longint sa, sb, q, r;
        logic   use_s;
`ifdef DIV_SIGNED_EN
        use_s = sd;
`else
        use_s = 1'b0 & sd;
`endif
        if (b == 32'd0) return 64'd0;
        if (use_s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ready_o && !ready_q) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result got %h, no result expected", bus.result_o);
                end else begin
                    last_exp = exp_q.pop_front();
                    if (bus.result_o !== last_exp) begin
                        errors++;
                        $display("FAIL result got %h expected %h", bus.result_o, last_exp);
                    end
                end
            end else if (bus.ready_o) begin
                checks++;
                if (bus.result_o !== last_exp) begin
                    errors++;
                    $display("FAIL result_hold got %h expected %h", bus.result_o, last_exp);
                end
            end
            if (!bus.ready_o) begin
                checks++;
                if (bus.result_o !== 64'd0) begin
                    errors++;
                    $display("FAIL idle_zero got %h expected 0", bus.result_o);
                end
            end
        end
        ready_q = bus.ready_o;
    end

    task automatic wait_ready(input int exp_lat, input string name);
        int n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.ready_o) break;
        end
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL latency_%s got %0d cycles expected %0d", name, n, exp_lat);
        end
    endtask

    task automatic finish_op(input int hold);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL drop_clear got ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sd, input int hold);
        @(negedge clk);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sd;
        bus.start_i      = 1'b1;
        exp_q.push_back(model(a, b, sd));
        @(posedge clk);
        #1;
        // operands must be ignored once accepted
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom);
        wait_ready((b == 32'd0) ? 2 : 33, "op");
        finish_op(hold);
    endtask

    initial begin
        logic [31:0] a, b;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_state got ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0, 2);
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 1);
        run_op(32'hFFFFFFF9, 32'd2, 1'b0, 0);
        run_op(32'h1234, 32'd0, 1'b0, 1);
        run_op(32'h1234, 32'd0, 1'b1, 0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, 0);
        run_op(32'd5, 32'hFFFFFFFF, 1'b0, 0);

        // abort at cycle 10, then restart 9/3 the next cycle
        @(negedge clk);
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        bus.signed_div_i = 1'b0;
        bus.start_i = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL annul_ready got %b expected 0", bus.ready_o);
        end
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd3;
        exp_q.push_back(model(32'd9, 32'd3, 1'b0));
        @(posedge clk);
        wait_ready(33, "after_annul");
        finish_op(0);

        // reset mid-operation
        @(negedge clk);
        bus.opdata1_i = 32'd77;
        bus.opdata2_i = 32'd5;
        bus.start_i = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset got ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;

        run_op(32'd6, 32'd4, 1'b0, 0);
        run_op(32'd15, 32'd5, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = a;
                3: b = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)};
                default: b = $urandom;
            endcase
            run_op(a, b, 1'($urandom), $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_results got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit integer divider for the EX stage, serving `div`/`divu`. EX starts it and holds a stall request until `ready_o` is seen. EX then forwards `result_o` into the HI/LO write path (`{remainder, quotient}` → HI/LO) toward EX/MEM. The divider is a radix-2 restoring divider driven by a 4-state FSM and retires one quotient bit per cycle.

## Interface
Parameters:
- `DIV_W`, 32: operand width; `result_o` is `2*DIV_W` bits.
- `CNT_W`, 6: iteration counter width; must hold the value `DIV_W`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `signed_div_i`  in  1  1 = signed division (`div`); 0 = unsigned (`divu`).
- `opdata1_i`  in  DIV_W  dividend.
- `opdata2_i`  in  DIV_W  divisor.
- `start_i`  in  1  request. Must stay high until EX has consumed `ready_o`.
- `annul_i`  in  1  abort the in-flight division (flush).
- `result_o`  out  2*DIV_W  `{remainder, quotient}`.
- `ready_o`  out  1  `result_o` valid.

## Operation
- States: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`. Reset state is `DivFree`.
- `rst`:
  - FSM → `DivFree`.
  - `result_o` = 0, `ready_o` = 0.
  - Counter and working registers cleared.
  - Reset takes priority over every other input in any state.
- `DivFree`:
  - `start_i`=1 and `annul_i`=0 and divisor == 0 → `DivByZero`.
  - `start_i`=1 and `annul_i`=0 and divisor != 0 → `DivOn`. On entry:
    - Latch |dividend| and |divisor|; negate an operand only if signed and its MSB is 1.
    - Latch both sign bits and the signed flag.
    - Working register = `{DIV_W'b0, dividend, 1'b0}`; counter = 0.
  - Otherwise stay; `ready_o` = 0, `result_o` = 0.
- `DivByZero`: unconditionally → `DivEnd` with the working result = 0.
- `DivOn`:
  - If `annul_i`=1 → `DivFree` immediately; outputs stay 0.
  - Otherwise perform one step. Trial = upper `DIV_W+1` bits minus divisor.
    - Trial negative: shift left, insert quotient bit 0.
    - Trial non-negative: replace upper part with the trial, shift left, insert quotient bit 1.
  - Counter increments each step.
  - After step `DIV_W` (counter == `DIV_W`) → `DivEnd`.
  - Sign fix-up is applied on this transition (signed only):
    - Quotient negated iff the operand signs differ.
    - Remainder negated iff the dividend was negative.
- `DivEnd`:
  - `ready_o` = 1; `result_o` = the final `{remainder, quotient}`. Both hold while `start_i`=1.
  - `start_i`=0 → `DivFree`; `ready_o` and `result_o` return to 0 on that edge.
- `annul_i` is ignored in `DivByZero` and `DivEnd`. EX drops `start_i` to discard those results.
- Arithmetic: two's complement, results modulo 2^DIV_W. Signed `0x80000000 / -1` gives quotient `0x80000000`, remainder 0. No trap is raised.

## Timing
- Edge E0 samples `start_i`.
- Nonzero divisor: `ready_o` rises after edge E(DIV_W+1), i.e. E33 for 32-bit operands (DIV_W steps plus entry).
- Divisor zero: `ready_o` rises after E2.
- `ready_o` and `result_o` are registered outputs with no combinational path from inputs.
- Back-to-back operation:
  - After `start_i` falls in `DivEnd`, the FSM reaches `DivFree` on the next edge.
  - A new `start_i` is sampled on the following edge. Minimum spacing is 2 cycles between the end of one result and the acceptance of the next request.
- Operands are sampled only at E0. Changes on `opdata*_i` afterwards have no effect.
- Stall interplay: EX keeps its stall request high from E0 until `ready_o`=1. While the request is high, EX/MEM injects bubbles. The divider itself ignores the stall vector.

## Configuration
- `DIV_SIGNED_EN` defined:
  - `signed_div_i` is honoured.
  - Operand negation and result sign fix-up logic are present.
- Not defined:
  - `signed_div_i` is ignored and every division is unsigned.
  - Negation and fix-up logic are not built.
  - Latency is unchanged.

## Test plan
- Unsigned 100 / 7, start held:
  - `ready_o` rises exactly 33 cycles after E0.
  - `result_o` = `{32'd2, 32'd14}`.
  - Dropping `start_i` clears both outputs on the next edge.
- Signed -7 / 2 (`DIV_SIGNED_EN`): `result_o` = `{32'hFFFFFFFF, 32'hFFFFFFFD}`. Same operands unsigned: quotient `0x7FFFFFFC`, remainder 1.
- Divisor 0, dividend `0x1234`: `ready_o` = 1 after E2; `result_o` = 0.
- Signed `0x80000000 / 0xFFFFFFFF`: quotient `0x80000000`, remainder 0.
- Abort and reset mid-operation:
  - `annul_i` pulsed at cycle 10 of `DivOn` → `DivFree`, `ready_o` stays 0. A fresh start the next cycle, 9 / 3, returns `{0, 3}` 33 cycles later.
  - `rst` asserted at cycle 20 → all outputs 0 the next cycle.
- Back-to-back 6 / 4 then 15 / 5 with `start_i` low for one cycle between requests: results `{2, 1}`, then `{0, 3}`, with no stale data on `result_o` in between.
